mux_sel_arbiter: RTL



---
 rtl/mux_sel_arbiter.sv | 74 +++++++
 1 files changed

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin owner arbiter for a shared mux; define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles
module mux_sel_arbiter #(
    parameter int N_REQ    = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout_evt
);
    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    if (N_REQ != (1 << SEL_W) || N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_cfg
        $error("mux_sel_arbiter: illegal parameter combination");
    end

    logic             state;
    logic [SEL_W-1:0] last_owner;
    logic [SEL_W-1:0] win;
    logic             rel;
    logic             expire;

    // descending scan so the closest requester after last_owner is assigned last and wins
    always_comb begin
        win = last_owner;
        for (int i = N_REQ; i >= 1; i--)
            if (req[last_owner + SEL_W'(i)]) win = last_owner + SEL_W'(i);
    end

    assign rel = done[sel] | ~req[sel];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            sel        <= '0;
            busy       <= 1'b0;
            last_owner <= SEL_W'(N_REQ - 1);
        end else if (state == IDLE) begin
            if (|req) begin
                state      <= GRANT;
                grant      <= N_REQ'(1) << win;
                sel        <= win;
                busy       <= 1'b1;
                last_owner <= win;
            end
        end else if (rel || expire) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
        end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold;
    assign expire = hold == 8'(MAX_HOLD - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hold        <= '0;
            timeout_evt <= 1'b0;
        end else begin
            hold        <= (state == GRANT) ? hold + 8'd1 : 8'd0;
            timeout_evt <= state == GRANT && expire && !rel;
        end
`else
    assign expire      = 1'b0;
    assign timeout_evt = 1'b0;
`endif
endmodule
